// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the host-stream performance monitor.
// The optional stall counter is enabled by defining PERF_MON_STALL_EN.
package perf_mon_pkg;

    localparam int unsigned PERF_CNT_BITS = 64;
    localparam int unsigned PERF_PKT_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 512;
    localparam int unsigned AXI_KEEP_BITS = AXI_DATA_BITS / 8;
    localparam int unsigned AXI_ID_BITS   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_mon_state_t;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] tdata;
        logic [AXI_KEEP_BITS-1:0] tkeep;
        logic                     tlast;
        logic [AXI_ID_BITS-1:0]   tid;
    } axis_beat_t;

    // Saturating increment of a bits-wide counter; bit 64 flags an increment attempted at all-ones.
    function automatic logic [64:0] sat_inc(input logic [63:0] v, input int unsigned bits);
        logic [63:0] max;
        max = (bits >= 64) ? '1 : ((64'(1) << bits) - 64'(1));
        if (v >= max) sat_inc = {1'b1, max};
        else          sat_inc = {1'b0, v + 64'(1)};
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Generic 2-entry AXI4SR skid register: full throughput, one cycle latency,
// ready toward the source is a flop so no combinational path crosses the stage.
module axis_skid_reg
    import perf_mon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       src_valid,
    output logic       src_ready,
    input  axis_beat_t src_beat,
    output logic       dst_valid,
    input  logic       dst_ready,
    output axis_beat_t dst_beat
);

    logic       skid_valid;
    axis_beat_t skid_beat;

    // The skid entry only fills when the output register is stalled while a beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid  <= 1'b0;
            dst_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
            src_ready  <= 1'b1;
        end else if (dst_ready || !dst_valid) begin
            if (skid_valid) begin
                dst_beat   <= skid_beat;
                dst_valid  <= 1'b1;
                skid_valid <= 1'b0;
                src_ready  <= 1'b1;
            end else begin
                dst_valid <= src_valid && src_ready;
                if (src_valid && src_ready) dst_beat <= src_beat;
            end
        end else if (src_valid && src_ready) begin
            skid_beat  <= src_beat;
            skid_valid <= 1'b1;
            src_ready  <= 1'b0;
        end
    end

endmodule

// File: rtl/host_stream_perf_mon.sv
// Pass-through monitor on the host-bound stream: skid-registered forwarding plus
// armed cycle/beat/packet counters. Define PERF_MON_STALL_EN for the stall counter.
module host_stream_perf_mon
    import perf_mon_pkg::*;
#(
    parameter int unsigned CNT_BITS = PERF_CNT_BITS,
    parameter int unsigned PKT_BITS = PERF_PKT_BITS
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     axis_in_tvalid,
    output logic                     axis_in_tready,
    input  logic [AXI_DATA_BITS-1:0] axis_in_tdata,
    input  logic [AXI_KEEP_BITS-1:0] axis_in_tkeep,
    input  logic                     axis_in_tlast,
    input  logic [AXI_ID_BITS-1:0]   axis_in_tid,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [AXI_DATA_BITS-1:0] axis_out_tdata,
    output logic [AXI_KEEP_BITS-1:0] axis_out_tkeep,
    output logic                     axis_out_tlast,
    output logic [AXI_ID_BITS-1:0]   axis_out_tid,
    input  logic                     start,
    input  logic                     clear,
    input  logic [PKT_BITS-1:0]      target_pkts,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_BITS-1:0]      cnt_cycles,
    output logic [CNT_BITS-1:0]      cnt_beats,
    output logic [PKT_BITS-1:0]      cnt_pkts,
`ifdef PERF_MON_STALL_EN
    output logic [CNT_BITS-1:0]      cnt_stall,
`endif
    output logic                     overflow
);

    axis_beat_t      in_beat;
    axis_beat_t      out_beat;
    perf_mon_state_t state;
    logic [PKT_BITS-1:0] target_q;

    assign in_beat = '{tdata: axis_in_tdata, tkeep: axis_in_tkeep,
                       tlast: axis_in_tlast, tid: axis_in_tid};

    axis_skid_reg u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .src_valid (axis_in_tvalid),
        .src_ready (axis_in_tready),
        .src_beat  (in_beat),
        .dst_valid (axis_out_tvalid),
        .dst_ready (axis_out_tready),
        .dst_beat  (out_beat)
    );

    assign axis_out_tdata = out_beat.tdata;
    assign axis_out_tkeep = out_beat.tkeep;
    assign axis_out_tlast = out_beat.tlast;
    assign axis_out_tid   = out_beat.tid;

    logic        beat_hs_c, pkt_hs_c, pkt_hit_c, ovf_c;
    logic [64:0] cyc_inc_c, beat_inc_c, pkt_inc_c;
`ifdef PERF_MON_STALL_EN
    logic        stall_c;
    logic [64:0] stall_inc_c;
`endif

    // Next counter values and saturation/terminal-count detection, sampled at axis_out.
    always_comb begin
        beat_hs_c  = axis_out_tvalid && axis_out_tready;
        pkt_hs_c   = beat_hs_c && axis_out_tlast;
        cyc_inc_c  = sat_inc(64'(cnt_cycles), CNT_BITS);
        beat_inc_c = sat_inc(64'(cnt_beats), CNT_BITS);
        pkt_inc_c  = sat_inc(64'(cnt_pkts), PKT_BITS);
        ovf_c      = cyc_inc_c[64] || (beat_hs_c && beat_inc_c[64]) || (pkt_hs_c && pkt_inc_c[64]);
`ifdef PERF_MON_STALL_EN
        stall_c     = axis_out_tvalid && !axis_out_tready;
        stall_inc_c = sat_inc(64'(cnt_stall), CNT_BITS);
        ovf_c       = ovf_c || (stall_c && stall_inc_c[64]);
`endif
        pkt_hit_c  = pkt_hs_c && (target_q != '0) && (PKT_BITS'(pkt_inc_c[63:0]) == target_q);
    end

    // Measurement FSM and counters; clear has priority over start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            target_q   <= '0;
            cnt_cycles <= '0;
            cnt_beats  <= '0;
            cnt_pkts   <= '0;
`ifdef PERF_MON_STALL_EN
            cnt_stall  <= '0;
`endif
            overflow   <= 1'b0;
        end else if (clear || start) begin
            state      <= clear ? IDLE : RUN;
            busy       <= !clear;
            done       <= 1'b0;
            if (!clear) target_q <= target_pkts;
            cnt_cycles <= '0;
            cnt_beats  <= '0;
            cnt_pkts   <= '0;
`ifdef PERF_MON_STALL_EN
            cnt_stall  <= '0;
`endif
            overflow   <= 1'b0;
        end else if (state == RUN) begin
            cnt_cycles <= CNT_BITS'(cyc_inc_c[63:0]);
            if (beat_hs_c) cnt_beats <= CNT_BITS'(beat_inc_c[63:0]);
            if (pkt_hs_c)  cnt_pkts  <= PKT_BITS'(pkt_inc_c[63:0]);
`ifdef PERF_MON_STALL_EN
            if (stall_c)   cnt_stall <= CNT_BITS'(stall_inc_c[63:0]);
`endif
            if (ovf_c) overflow <= 1'b1;
            if (pkt_hit_c) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_host_stream_perf_mon.sv
// Directed bench for host_stream_perf_mon; covers the stall counter when PERF_MON_STALL_EN is defined.
module tb_host_stream_perf_mon;
    import perf_mon_pkg::*;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic                     in_valid = 1'b0, in_ready;
    logic [AXI_DATA_BITS-1:0] in_data = '0;
    logic [AXI_KEEP_BITS-1:0] in_keep = '0;
    logic                     in_last = 1'b0;
    logic [AXI_ID_BITS-1:0]   in_id = '0;
    logic                     out_valid, out_ready = 1'b1;
    logic [AXI_DATA_BITS-1:0] out_data;
    logic [AXI_KEEP_BITS-1:0] out_keep;
    logic                     out_last;
    logic [AXI_ID_BITS-1:0]   out_id;
    logic                     start = 1'b0, clear = 1'b0;
    logic [31:0]              target = '0;
    logic                     busy, done, overflow;
    logic [63:0]              cyc, beats;
    logic [31:0]              pkts;
`ifdef PERF_MON_STALL_EN
    logic [63:0]              stall;
`endif

    // Narrow-counter instance for saturation
    logic                     s_valid = 1'b0, s_ready, s_out_valid, s_last_o, s_start = 1'b0;
    logic                     s_busy, s_done, s_ovf;
    logic [AXI_DATA_BITS-1:0] s_data_o;
    logic [AXI_KEEP_BITS-1:0] s_keep_o;
    logic [AXI_ID_BITS-1:0]   s_id_o;
    logic [3:0]               s_cyc, s_beats;
    logic [31:0]              s_pkts;
`ifdef PERF_MON_STALL_EN
    logic [3:0]               s_stall;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    host_stream_perf_mon dut (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tvalid(in_valid), .axis_in_tready(in_ready), .axis_in_tdata(in_data),
        .axis_in_tkeep(in_keep), .axis_in_tlast(in_last), .axis_in_tid(in_id),
        .axis_out_tvalid(out_valid), .axis_out_tready(out_ready), .axis_out_tdata(out_data),
        .axis_out_tkeep(out_keep), .axis_out_tlast(out_last), .axis_out_tid(out_id),
        .start(start), .clear(clear), .target_pkts(target),
        .busy(busy), .done(done), .cnt_cycles(cyc), .cnt_beats(beats), .cnt_pkts(pkts),
`ifdef PERF_MON_STALL_EN
        .cnt_stall(stall),
`endif
        .overflow(overflow)
    );

    host_stream_perf_mon #(.CNT_BITS(4), .PKT_BITS(32)) dut_s (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tvalid(s_valid), .axis_in_tready(s_ready), .axis_in_tdata(in_data),
        .axis_in_tkeep(in_keep), .axis_in_tlast(1'b1), .axis_in_tid(in_id),
        .axis_out_tvalid(s_out_valid), .axis_out_tready(1'b1), .axis_out_tdata(s_data_o),
        .axis_out_tkeep(s_keep_o), .axis_out_tlast(s_last_o), .axis_out_tid(s_id_o),
        .start(s_start), .clear(1'b0), .target_pkts(32'd0),
        .busy(s_busy), .done(s_done), .cnt_cycles(s_cyc), .cnt_beats(s_beats), .cnt_pkts(s_pkts),
`ifdef PERF_MON_STALL_EN
        .cnt_stall(s_stall),
`endif
        .overflow(s_ovf)
    );

    function automatic axis_beat_t mk(input int i);
        axis_beat_t b;
        b.tdata = {16{32'hC0DE_0000 | 32'(i)}};
        b.tkeep = AXI_KEEP_BITS'(~64'(i));
        b.tlast = ((i % 8) == 7);
        b.tid   = AXI_ID_BITS'(i / 8);
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Streams nbeats beats, optionally throttling axis_out, and scores every output beat in order.
    task automatic run_traffic(input int nbeats, input bit bp, output int cycles,
                               output int stalls, output int got);
        int sent = 0;
        bit in_hs;
        axis_beat_t b, o;
        cycles = 0; stalls = 0; got = 0;
        while (got < nbeats && cycles < 400) begin
            b = mk(sent);
            in_valid  = (sent < nbeats);
            in_data   = b.tdata; in_keep = b.tkeep; in_last = b.tlast; in_id = b.tid;
            out_ready = bp ? (cycles % 2 == 1) : 1'b1;
            @(negedge aclk);
            in_hs = in_valid && in_ready;
            if (out_valid && out_ready) begin
                o = '{tdata: out_data, tkeep: out_keep, tlast: out_last, tid: out_id};
                vectors++;
                assert (o === mk(got)) else begin
                    miscompares++;
                    $error("FAIL beat%0d: observed id %0h last %0b data %0h expected id %0h data %0h",
                           got, o.tid, o.tlast, o.tdata[31:0], mk(got).tid, mk(got).tdata[31:0]);
                end
                got++;
            end else if (out_valid) begin
                stalls++;
            end
            tick();
            cycles++;
            if (in_hs) sent++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    endtask

    int ncyc, nstall, ngot;

    initial begin
        // Reset values
        #23;
        check("rst_tready", 64'(in_ready), 64'd1);
        check("rst_tvalid", 64'(out_valid), 64'd0);
        aresetn = 1'b1;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cycles", cyc, 64'd0);
        check("rst_beats", beats, 64'd0);
        check("rst_pkts", 64'(pkts), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        // Four back-to-back 8-beat packets, no backpressure
        target = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_after_start", 64'(busy), 64'd1);
        run_traffic(32, 1'b0, ncyc, nstall, ngot);
        check("t1_got", 64'(ngot), 64'd32);
        check("t1_beats", beats, 64'd32);
        check("t1_pkts", 64'(pkts), 64'd4);
        check("t1_cycles", cyc, 64'd33);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_ovf", 64'(overflow), 64'd0);
`ifdef PERF_MON_STALL_EN
        check("t1_stall", stall, 64'd0);
`endif
        repeat (3) tick();
        check("t1_done_holds_cycles", cyc, 64'd33);

        // Same traffic with output ready low every other cycle; target change mid-run ignored
        target = 32'd4; start = 1'b1;
        tick();
        start = 1'b0; target = 32'd2;
        check("t2_restart_cycles", cyc, 64'd0);
        run_traffic(32, 1'b1, ncyc, nstall, ngot);
        check("t2_got", 64'(ngot), 64'd32);
        check("t2_beats", beats, 64'd32);
        check("t2_pkts", 64'(pkts), 64'd4);
        check("t2_cycles", cyc, 64'(ncyc));
        check("t2_done", 64'(done), 64'd1);
`ifdef PERF_MON_STALL_EN
        check("t2_stall", stall, 64'(nstall));
`endif

        // start and clear together during RUN: clear wins
        target = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("t3_cycles_running", cyc, 64'd5);
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_done", 64'(done), 64'd0);
        check("t3_cycles", cyc, 64'd0);
        check("t3_beats", beats, 64'd0);
        tick();
        check("t3_idle_cycles", cyc, 64'd0);

        // Saturation on 4-bit counters, unbounded run, 20 single-beat packets
        s_start = 1'b1;
        tick();
        s_start = 1'b0; s_valid = 1'b1;
        repeat (20) tick();
        s_valid = 1'b0;
        repeat (3) tick();
        check("t4_beats", 64'(s_beats), 64'd15);
        check("t4_cycles", 64'(s_cyc), 64'd15);
        check("t4_pkts", 64'(s_pkts), 64'd20);
        check("t4_ovf", 64'(s_ovf), 64'd1);
        check("t4_busy", 64'(s_busy), 64'd1);
        check("t4_done", 64'(s_done), 64'd0);

        // Reset mid-packet, then a fresh measurement
        target = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = mk(i).tdata; in_keep = mk(i).tkeep;
            in_last = mk(i).tlast; in_id = mk(i).tid;
            tick();
        end
        check("t5_pre_tvalid", 64'(out_valid), 64'd1);
        #1 aresetn = 1'b0;
        #1;
        check("t5_async_tvalid", 64'(out_valid), 64'd0);
        check("t5_async_tready", 64'(in_ready), 64'd1);
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_cycles", cyc, 64'd0);
        check("t5_async_beats", beats, 64'd0);
        in_valid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_traffic(8, 1'b0, ncyc, nstall, ngot);
        check("t5_beats", beats, 64'd8);
        check("t5_pkts", 64'(pkts), 64'd1);
        check("t5_cycles", cyc, 64'd9);
        check("t5_done", 64'(done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/host_stream_perf_mon.md
# host_stream_perf_mon

Pass-through monitor on the host-bound stream. It sits directly downstream of the vFPGA user logic's `axis_host_src` and feeds the shell's host stream. Every beat is forwarded through a registered skid stage. While a measurement is armed, the block counts cycles, accepted beats, completed packets and (optionally) backpressure stalls. Software-facing logic reads the results through plain status ports.

## Interface
Parameters:
- `CNT_BITS`, 64: width of the cycle, beat and stall counters.
- `PKT_BITS`, 32: width of the packet counter and of `target_pkts`.

Ports (clock and reset first):
- `aclk` in, 1: single clock for all logic.
- `aresetn` in, 1: asynchronous active-low reset.
- `axis_in` AXI4SR.s, `AXI_DATA_BITS`: stream from user logic.
- `axis_out` AXI4SR.m, `AXI_DATA_BITS`: stream toward host.
- `start` in, 1: single-cycle pulse that arms a measurement.
- `clear` in, 1: single-cycle pulse that zeroes counters and returns to IDLE.
- `target_pkts` in, `PKT_BITS`: packet count that ends a run. 0 means unbounded.
- `busy` out, 1: high in RUN.
- `done` out, 1: high in DONE.
- `cnt_cycles` out, `CNT_BITS`: cycles counted in RUN.
- `cnt_beats` out, `CNT_BITS`: `axis_out` handshakes counted in RUN.
- `cnt_pkts` out, `PKT_BITS`: `axis_out` handshakes with `tlast` counted in RUN.
- `cnt_stall` out, `CNT_BITS`: `axis_out` cycles with tvalid high and tready low in RUN. Present only with the macro.
- `overflow` out, 1: sticky flag, set when any counter saturates.

## Operation
- Datapath:
  - 2-entry skid register sustains full throughput. Latency is 1 cycle.
  - `tdata`, `tkeep`, `tlast` and `tid` are forwarded unmodified.
  - Forwarding is independent of FSM state; the monitor never stalls the stream.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. All counters zero on entry to RUN.
  - RUN → DONE on the cycle of the `axis_out` tlast handshake that brings `cnt_pkts` to `target_pkts`, when `target_pkts` is nonzero.
  - RUN → RUN on `start`: restart with counters zeroed.
  - DONE → RUN on `start`, counters zeroed. DONE holds all counters stable.
  - Any state → IDLE on `clear`, counters and `overflow` zeroed.
  - `clear` and `start` in the same cycle: `clear` wins.
- Counting in RUN:
  - `cnt_cycles` increments every cycle.
  - Beats, packets and stalls are sampled at `axis_out`.
  - The final handshake that ends the run is counted.
- Arithmetic:
  - Unsigned counters saturate at all-ones; they never wrap.
  - Saturation sets `overflow`, which stays set until `clear` or the next `start`.
- `target_pkts` is sampled only on `start`; changes during RUN are ignored.

## Timing
- Reset values:
  - `axis_out.tvalid` 0, skid empty, `axis_in.tready` 1.
  - State IDLE; `busy` 0, `done` 0.
  - All counters 0; `overflow` 0.
- `start` at cycle T sets `busy` at T+1. Cycle T+1 is the first counted cycle; handshakes at T are not counted.
- Final handshake at cycle F: `done` is 1 and `busy` is 0 at F+1. `cnt_cycles` includes F.
- Counter outputs are registered and reflect events up to the previous cycle.
- Reset asserted mid-run: state, counters and skid contents are discarded immediately. In-flight beats are lost; upstream must re-send.

## Configuration
- `PERF_MON_STALL_EN` defined: the stall counter and the `cnt_stall` port exist, and stall saturation feeds `overflow`.
- `PERF_MON_STALL_EN` undefined: no stall logic and no `cnt_stall` port.

## Structure
- Shared package `perf_mon_pkg`:
  - state enum `perf_mon_state_t` (IDLE/RUN/DONE).
  - default-width constants `PERF_CNT_BITS` and `PERF_PKT_BITS`.
  - saturating-increment function.
- Sub-module `axis_skid_reg`: the generic 2-entry AXI4SR skid buffer, reusable on other host streams.
- The monitor FSM and counters live in the top module.

## Test plan
- Reset: after release, `axis_in.tready`=1, `axis_out.tvalid`=0, all counters 0, `busy`=`done`=0.
- `target_pkts`=4, 4 back-to-back 8-beat packets starting at T+1, `axis_out.tready`=1 → `cnt_beats`=32, `cnt_pkts`=4, `cnt_cycles`=33, `cnt_stall`=0, `done`=1. Output data matches input bit-exactly.
- Same traffic with `axis_out.tready` low every other cycle → no beats lost or reordered, `cnt_beats`=32. With the macro, `cnt_stall` equals the count of valid-and-not-ready cycles.
- `start` and `clear` asserted in the same cycle during RUN → IDLE, counters 0, `busy`=0.
- `CNT_BITS`=4, `target_pkts`=0, 20 single-beat packets → `cnt_beats`=15, `overflow`=1, state stays RUN.
- `aresetn` pulsed low mid-packet → outputs return to reset values asynchronously. A new `start` then counts from 0.
